// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU mode codes, main-control
// ALUOp classes, LEGv8 R-type and immediate opcodes, and the payload record
// carried from decode to the execute-stage ALU.
package alu_pkg;

    // Operand width of the payload record; the issue stage's W must match it.
    localparam int ALU_W = 64;

    // ALU mode codes
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_LSR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    // Main-control instruction classes
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // R-type opcodes, full instruction bits [31:21]
    localparam logic [10:0] OPC_R_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_R_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_R_AND = 11'b10001010000;
    localparam logic [10:0] OPC_R_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_R_LSL = 11'b11010011011;
    localparam logic [10:0] OPC_R_LSR = 11'b11010011010;

    // Immediate opcodes, instruction bits [31:22]; bit 21 belongs to the immediate
    localparam logic [9:0] OPC_I_ADD = 10'b1001000100;
    localparam logic [9:0] OPC_I_SUB = 10'b1101000100;
    localparam logic [9:0] OPC_I_AND = 10'b1001001000;
    localparam logic [9:0] OPC_I_ORR = 10'b1011001000;

    typedef struct packed {
        logic [3:0]       mode;
        logic [ALU_W-1:0] r1;
        logic [ALU_W-1:0] r2;
        logic             illegal;
    } alu_payload_t;

    // Shifts take their second operand from the shamt field, not from RegB.
    function automatic logic is_shift(input logic [3:0] mode);
        return (mode == ALU_LSL) || (mode == ALU_LSR);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: turns (ALUOp, Opcode) into a mode code,
// flags undecodable R-type/immediate opcodes, and selects the ALU operands.
// Illegal entries still produce a payload (PassB of zero) so the pipeline
// keeps flowing and downstream exception logic can act on the flag.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic [5:0]       shamt,
    input  logic [ALU_W-1:0] reg_a,
    input  logic [ALU_W-1:0] reg_b,
    output alu_payload_t     payload
);

    logic [3:0] mode;
    logic       illegal;

    // Mode decode by instruction class, then by opcode within R-type / immediate
    always_comb begin
        mode    = ALU_PASSB;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_MEM: mode = ALU_ADD;
            ALUOP_CBZ: mode = ALU_PASSB;
            ALUOP_RTYPE: begin
                case (opcode)
                    OPC_R_ADD: mode = ALU_ADD;
                    OPC_R_SUB: mode = ALU_SUB;
                    OPC_R_AND: mode = ALU_AND;
                    OPC_R_ORR: mode = ALU_OR;
                    OPC_R_LSL: mode = ALU_LSL;
                    OPC_R_LSR: mode = ALU_LSR;
                    default: begin
                        mode    = ALU_PASSB;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                case (opcode[10:1])
                    OPC_I_ADD: mode = ALU_ADD;
                    OPC_I_SUB: mode = ALU_SUB;
                    OPC_I_AND: mode = ALU_AND;
                    OPC_I_ORR: mode = ALU_OR;
                    default: begin
                        mode    = ALU_PASSB;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Operand selection: shift amount zero-extended for shifts, zero for illegal
    always_comb begin
        payload         = '0;
        payload.mode    = mode;
        payload.illegal = illegal;
        payload.r1      = reg_a;
        if (is_shift(mode)) begin
            payload.r2 = {{(ALU_W-6){1'b0}}, shamt};
        end else if (illegal) begin
            payload.r2 = '0;
        end else begin
            payload.r2 = reg_b;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the 64-bit ALU. Decodes the control fields ahead
// of the capture register and presents Mode/R1/R2/Illegal to the ALU behind a
// valid/ready handshake, with a synchronous flush of every held entry.
//
// Build option ALU_ISSUE_SKID_EN:
//   defined   - two entries (output register + skid register); InReady is a
//               flop (!skid_valid) with no combinational path from OutReady.
//   undefined - single output register; InReady = !OutValid || OutReady.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         CLK,
    input  logic         Reset_n,
    input  logic         Flush,
    input  logic         InValid,
    output logic         InReady,
    input  logic [10:0]  Opcode,
    input  logic [1:0]   ALUOp,
    input  logic [5:0]   Shamt,
    input  logic [W-1:0] RegA,
    input  logic [W-1:0] RegB,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [3:0]   Mode,
    output logic [W-1:0] R1,
    output logic [W-1:0] R2,
    output logic         Illegal
);

    alu_payload_t dec_payload;
    alu_payload_t out_payload;
    logic         out_valid;
    logic         in_xfer;

    alu_ctrl_decode u_decode (
        .alu_op  (ALUOp),
        .opcode  (Opcode),
        .shamt   (Shamt),
        .reg_a   (RegA),
        .reg_b   (RegB),
        .payload (dec_payload)
    );

    assign in_xfer = InValid && InReady;

`ifdef ALU_ISSUE_SKID_EN

    alu_payload_t skid_payload;
    logic         skid_valid;

    // Registered ready: only the skid slot being full can refuse an entry
    assign InReady = !skid_valid;

    // Output register refills from the skid slot first so order is preserved;
    // an entry accepted while the output is stalled parks in the skid slot
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid    <= 1'b0;
            out_payload  <= '0;
            skid_valid   <= 1'b0;
            skid_payload <= '0;
        end else if (Flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || OutReady) begin
            if (skid_valid) begin
                out_payload <= skid_payload;
                out_valid   <= 1'b1;
                skid_valid  <= 1'b0;
            end else if (in_xfer) begin
                out_payload <= dec_payload;
                out_valid   <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_payload <= dec_payload;
            skid_valid   <= 1'b1;
        end
    end

`else

    // Single entry: accept whenever the register is empty or draining this cycle
    assign InReady = !out_valid || OutReady;

    // Reload on every input transfer (no bubble when draining), else drain
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
        end else if (Flush) begin
            out_valid <= 1'b0;
        end else if (in_xfer) begin
            out_payload <= dec_payload;
            out_valid   <= 1'b1;
        end else if (OutReady) begin
            out_valid <= 1'b0;
        end
    end

`endif

    assign OutValid = out_valid;
    assign Mode     = out_payload.mode;
    assign R1       = out_payload.r1;
    assign R2       = out_payload.r2;
    assign Illegal  = out_payload.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a decode vector table, random
// traffic against a queue-based reference model, and hand-written sequences
// for reset, back-pressure capacity and flush.
module tb_alu_issue_stage;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [10:0] Opcode;
    logic [1:0]  ALUOp;
    logic [5:0]  Shamt;
    logic [63:0] RegA;
    logic [63:0] RegB;
    logic        OutValid;
    logic        OutReady;
    logic [3:0]  Mode;
    logic [63:0] R1;
    logic [63:0] R2;
    logic        Illegal;

    alu_issue_stage #(.W(64)) dut (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .Opcode   (Opcode),
        .ALUOp    (ALUOp),
        .Shamt    (Shamt),
        .RegA     (RegA),
        .RegB     (RegB),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Mode     (Mode),
        .R1       (R1),
        .R2       (R2),
        .Illegal  (Illegal)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  mode;
        logic [63:0] r1;
        logic [63:0] r2;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [10:0] opc;
        logic [5:0]  sh;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  mode;
        logic [63:0] r2;
        logic        ill;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t model_q[$];

    logic [10:0] r_ops [6];
    logic [9:0]  i_ops [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written straight from the mode/opcode tables
    function automatic exp_t ref_decode(input logic [1:0] op, input logic [10:0] opc,
                                        input logic [5:0] sh, input logic [63:0] a,
                                        input logic [63:0] b);
        exp_t e;
        logic [9:0] hi;
        hi     = opc[10:1];
        e.r1   = a;
        e.r2   = b;
        e.ill  = 1'b0;
        e.mode = 4'd7;
        if (op == 2'b00) e.mode = 4'd2;
        else if (op == 2'b01) e.mode = 4'd7;
        else if (op == 2'b10) begin
            if      (opc == 11'b10001011000) e.mode = 4'd2;
            else if (opc == 11'b11001011000) e.mode = 4'd6;
            else if (opc == 11'b10001010000) e.mode = 4'd0;
            else if (opc == 11'b10101010000) e.mode = 4'd1;
            else if (opc == 11'b11010011011) begin e.mode = 4'd3; e.r2 = 64'(sh); end
            else if (opc == 11'b11010011010) begin e.mode = 4'd4; e.r2 = 64'(sh); end
            else begin e.mode = 4'd7; e.r2 = 64'd0; e.ill = 1'b1; end
        end else begin
            if      (hi == 10'b1001000100) e.mode = 4'd2;
            else if (hi == 10'b1101000100) e.mode = 4'd6;
            else if (hi == 10'b1001001000) e.mode = 4'd0;
            else if (hi == 10'b1011001000) e.mode = 4'd1;
            else begin e.mode = 4'd7; e.r2 = 64'd0; e.ill = 1'b1; end
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] opc,
                         input logic [5:0] sh, input logic [63:0] a, input logic [63:0] b);
        InValid = v;
        ALUOp   = op;
        Opcode  = opc;
        Shamt   = sh;
        RegA    = a;
        RegB    = b;
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // One randomized cycle: inputs set at negedge, outputs checked against the
    // model, then the model advances by the transfers seen at the clock edge
    task automatic rand_step();
        logic        in_x;
        logic        out_x;
        logic        exp_ready;
        exp_t        e;
        logic [1:0]  op;
        logic [10:0] opc;
        int          sel;
        op  = 2'($urandom);
        sel = int'($urandom_range(0, 9));
        if (op == 2'b10) opc = (sel < 8) ? r_ops[sel % 6] : 11'($urandom);
        else if (op == 2'b11) opc = (sel < 8) ? {i_ops[sel % 4], 1'($urandom)} : 11'($urandom);
        else opc = 11'($urandom);
        drive(($urandom_range(0, 9) < 7), op, opc, 6'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom});
        OutReady = ($urandom_range(0, 9) < 6);
        Flush    = ($urandom_range(0, 99) < 3);
        #1;
`ifdef ALU_ISSUE_SKID_EN
        exp_ready = (model_q.size() < 2);
`else
        exp_ready = (model_q.size() == 0) || OutReady;
`endif
        chk("rand_in_ready", 64'(InReady), 64'(exp_ready));
        chk("rand_out_valid", 64'(OutValid), 64'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            chk("rand_mode", 64'(Mode), 64'(model_q[0].mode));
            chk("rand_r1", R1, model_q[0].r1);
            chk("rand_r2", R2, model_q[0].r2);
            chk("rand_illegal", 64'(Illegal), 64'(model_q[0].ill));
        end
        in_x  = InValid && InReady;
        out_x = OutValid && OutReady;
        e     = ref_decode(ALUOp, Opcode, Shamt, RegA, RegB);
        @(posedge CLK);
        if (Flush) begin
            model_q.delete();
        end else begin
            if (out_x && model_q.size() > 0) void'(model_q.pop_front());
            if (in_x) model_q.push_back(e);
        end
        @(negedge CLK);
    endtask

    vec_t vecs [15];

    initial begin
        r_ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                  11'b10101010000, 11'b11010011011, 11'b11010011010};
        i_ops = '{10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000};

        vecs[0]  = '{2'b10, 11'b11001011000, 6'd0,  64'd10, 64'd3, 4'b0110, 64'd3, 1'b0};
        vecs[1]  = '{2'b10, 11'b11010011011, 6'd5,  64'd7, 64'hFFFF, 4'b0011, 64'd5, 1'b0};
        vecs[2]  = '{2'b11, 11'b10010001000, 6'd9,  64'd1, 64'd44, 4'b0010, 64'd44, 1'b0};
        vecs[3]  = '{2'b11, 11'b10010001001, 6'd9,  64'd2, 64'd45, 4'b0010, 64'd45, 1'b0};
        vecs[4]  = '{2'b10, 11'b11111111111, 6'd3,  64'd5, 64'd99, 4'b0111, 64'd0, 1'b1};
        vecs[5]  = '{2'b00, 11'b11111000010, 6'd1,  64'd8, 64'h10, 4'b0010, 64'h10, 1'b0};
        vecs[6]  = '{2'b01, 11'b10110100000, 6'd1,  64'd8, 64'h20, 4'b0111, 64'h20, 1'b0};
        vecs[7]  = '{2'b10, 11'b11010011010, 6'd63, 64'hF0, 64'h1234, 4'b0100, 64'd63, 1'b0};
        vecs[8]  = '{2'b10, 11'b10001010000, 6'd2,  64'hA, 64'hC, 4'b0000, 64'hC, 1'b0};
        vecs[9]  = '{2'b10, 11'b10101010000, 6'd2,  64'hB, 64'hD, 4'b0001, 64'hD, 1'b0};
        vecs[10] = '{2'b11, 11'b11010001001, 6'd0,  64'h3, 64'h7, 4'b0110, 64'h7, 1'b0};
        vecs[11] = '{2'b11, 11'b10110010001, 6'd0,  64'h4, 64'h8, 4'b0001, 64'h8, 1'b0};
        vecs[12] = '{2'b11, 11'b10010010000, 6'd0,  64'h5, 64'h9, 4'b0000, 64'h9, 1'b0};
        vecs[13] = '{2'b11, 11'b11111111111, 6'd7,  64'h6, 64'hA, 4'b0111, 64'd0, 1'b1};
        vecs[14] = '{2'b10, 11'b10001011000, 6'd7,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'b0010, 64'h1, 1'b0};

        Reset_n  = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b0;
        drive(1'b0, 2'b00, 11'd0, 6'd0, 64'd0, 64'd0);
        repeat (3) @(negedge CLK);
        chk("reset_out_valid", 64'(OutValid), 64'd0);
        chk("reset_mode", 64'(Mode), 64'd0);
        chk("reset_r1", R1, 64'd0);
        chk("reset_r2", R2, 64'd0);
        chk("reset_illegal", 64'(Illegal), 64'd0);
        Reset_n = 1'b1;
        #1;
        chk("reset_in_ready", 64'(InReady), 64'd1);
        @(negedge CLK);

        // Decode table streamed back-to-back with OutReady held high
        OutReady = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].opc, vecs[i].sh, vecs[i].a, vecs[i].b);
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(OutValid), 64'd1);
            chk($sformatf("vec%0d_mode", i), 64'(Mode), 64'(vecs[i].mode));
            chk($sformatf("vec%0d_r1", i), R1, vecs[i].a);
            chk($sformatf("vec%0d_r2", i), R2, vecs[i].r2);
            chk($sformatf("vec%0d_illegal", i), 64'(Illegal), 64'(vecs[i].ill));
        end
        InValid = 1'b0;
        tick();
        chk("vec_drain_valid", 64'(OutValid), 64'd0);

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) rand_step();

        // Reset mid-stall: outputs clear immediately, nothing replays afterwards
        Flush    = 1'b0;
        OutReady = 1'b0;
        drive(1'b1, 2'b10, 11'b11001011000, 6'd0, 64'd77, 64'd11);
        tick();
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(OutValid), 64'd0);
        chk("midrst_mode", 64'(Mode), 64'd0);
        chk("midrst_r1", R1, 64'd0);
        chk("midrst_r2", R2, 64'd0);
        chk("midrst_illegal", 64'(Illegal), 64'd0);
        model_q.delete();
        InValid = 1'b0;
        @(negedge CLK);
        Reset_n = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(InReady), 64'd1);
        chk("midrst_valid_after", 64'(OutValid), 64'd0);
        OutReady = 1'b1;
        tick();
        chk("midrst_no_replay", 64'(OutValid), 64'd0);

        // Capacity under back-pressure
        OutReady = 1'b0;
        drive(1'b1, 2'b10, 11'b11001011000, 6'd0, 64'hA1, 64'h2);
        tick();
        chk("bp_a_valid", 64'(OutValid), 64'd1);
        chk("bp_a_r1", R1, 64'hA1);
`ifdef ALU_ISSUE_SKID_EN
        chk("bp_ready_after_a", 64'(InReady), 64'd1);
        drive(1'b1, 2'b10, 11'b10001011000, 6'd0, 64'hB2, 64'h6);
        tick();
        chk("bp_a_held", R1, 64'hA1);
        chk("bp_ready_after_b", 64'(InReady), 64'd0);
        drive(1'b1, 2'b10, 11'b10001010000, 6'd0, 64'hC3, 64'h9);
        tick();
        chk("bp_c_refused_ready", 64'(InReady), 64'd0);
        chk("bp_a_still_held", R1, 64'hA1);
        chk("bp_a_mode", 64'(Mode), 64'b0110);
        InValid  = 1'b0;
        OutReady = 1'b1;
        #1;
        chk("bp_ready_not_comb", 64'(InReady), 64'd0);
        tick();
        chk("bp_b_valid", 64'(OutValid), 64'd1);
        chk("bp_b_r1", R1, 64'hB2);
        chk("bp_b_mode", 64'(Mode), 64'b0010);
        tick();
        chk("bp_c_not_delivered", 64'(OutValid), 64'd0);
`else
        drive(1'b1, 2'b10, 11'b10001011000, 6'd0, 64'hB2, 64'h6);
        #1;
        chk("bp_ready_full", 64'(InReady), 64'd0);
        tick();
        chk("bp_a_held", R1, 64'hA1);
        chk("bp_a_mode", 64'(Mode), 64'b0110);
        InValid  = 1'b0;
        OutReady = 1'b1;
        #1;
        chk("bp_ready_draining", 64'(InReady), 64'd1);
        tick();
        chk("bp_b_not_delivered", 64'(OutValid), 64'd0);
`endif

        // Flush together with an input transfer while one entry is held
        OutReady = 1'b0;
        drive(1'b1, 2'b10, 11'b10101010000, 6'd0, 64'hD4, 64'h1);
        tick();
        chk("flush_held_valid", 64'(OutValid), 64'd1);
        drive(1'b1, 2'b10, 11'b10001011000, 6'd0, 64'hE5, 64'h2);
        Flush = 1'b1;
        tick();
        Flush   = 1'b0;
        InValid = 1'b0;
        chk("flush_out_valid", 64'(OutValid), 64'd0);
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("flush_quiet%0d", i), 64'(OutValid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
